z80_bus_responder: RTL
======================

// Module: z80_bus_responder
// PURPOSE
//  Target side of the Z80 external bus for the test SoC, clocked by eclk. Decodes the strobes
//  from chip_z80 (_mreq/_iorq/_rd/_wr/_m1/_rfsh) and serves memory reads and writes from an
//  internal RAM. Provides one 8-bit I/O port, a programmable _wait generator and a mode-2 style
//  interrupt source. It replaces the constant db_i tie-off.
// PARAMETERS
//  ADDR_BITS   12      RAM depth = 2**ADDR_BITS bytes; ab is truncated to ADDR_BITS (aliasing wraps)
//  MEM_WAIT    0       eclk cycles _wait held low per memory rd/wr access (0..15)
//  IO_WAIT     2       eclk cycles _wait held low per I/O access or INTA (0..15)
//  IO_PORT     8'h10   ab[7:0] decoded as the I/O port
//  INIT_FILE   ""      $readmemh image loaded at time 0; "" -> RAM all 8'h00
// PORTS
//  eclk        in   1   system clock; all state changes on posedge
//  ereset      in   1   asynchronous, active-high reset
//  ab          in   16  address bus from core
//  db_o        in   8   data driven by core (valid during write strobe)
//  _m1,_mreq,_iorq,_rd,_wr,_rfsh  in 1 each  active-low bus strobes from core
//  db_i        out  8   data to core
//  _wait       out  1   active-low wait request
//  _int        out  1   active-low interrupt request
//  irq_req     in   1   one-cycle pulse: raise interrupt
//  irq_vec     in   8   byte returned during interrupt acknowledge
//  io_in       in   8   value returned on I/O read of IO_PORT
//  io_out      out  8   last byte written to IO_PORT
//  io_wstb     out  1   one-cycle pulse when io_out updates
// BEHAVIOUR
//  Reset (async): db_i=8'hFF, _wait=1, _int=1, io_out=8'h00, io_wstb=0, FSM=IDLE. RAM is not reset.
//  Strobes are registered each eclk (prev copies). A cycle starts on the first eclk at which the
//  strobe combination becomes true after being false in the previous sample:
//   MEM_RD : !_mreq & !_rd & _rfsh      MEM_WR : !_mreq & !_wr
//   IO_RD  : !_iorq & !_rd & _m1        IO_WR  : !_iorq & !_wr & _m1
//   INTA   : !_iorq & !_m1
//   Refresh (!_mreq & !_rfsh) is ignored; db_i stays 8'hFF.
//  FSM: IDLE -> WAITST (if wait count > 0, else straight to ACTIVE) -> ACTIVE -> IDLE.
//   WAITST: _wait=0, down-counter loaded with MEM_WAIT/IO_WAIT, exits when count reaches 1.
//   ACTIVE: held until all of _mreq,_iorq are high, then IDLE.
//  Read data: registered, so db_i is valid 1 eclk after cycle start and held through ACTIVE.
//   MEM_RD -> mem[ab[ADDR_BITS-1:0]]; IO_RD with ab[7:0]==IO_PORT -> io_in, else 8'hFF;
//   INTA -> irq_vec. db_i returns to 8'hFF on the eclk after the strobes deassert.
//  Write: db_o is captured on the eclk where _wr rises (trailing edge), so late data is used.
//   MEM_WR -> RAM write of the captured byte. IO_WR to IO_PORT -> io_out updated, io_wstb=1 for
//   one eclk. Writes to other ports are dropped.
//  Interrupt: irq_req sets a pending flag and _int=0. The flag clears at the start of INTA, and
//   _int returns to 1 on the same eclk. irq_req coincident with INTA start leaves the flag set
//   (new request wins). Repeated irq_req while pending is a no-op.
//  Strobes vanishing during WAITST (core reset): abort to IDLE with _wait=1 and no write.
//  ereset mid-cycle: immediate return to reset values.
//  Simultaneous _rd & _wr low: treated as a read; no write is performed.
// TESTING
//  1 Preload mem[12'h000]=8'h3E, mem[12'h001]=8'h42, MEM_WAIT=0; run the core from reset ->
//    first M1 fetch at ab=0000 sees db_i=8'h3E; the next access sees db_i=8'h42.
//  2 MEM_WR to ab=16'h1234 with db_o=8'hA5, then MEM_RD of 16'h0234 (ADDR_BITS=12) ->
//    db_i=8'hA5 (alias wrap).
//  3 MEM_WAIT=3 -> _wait low exactly 3 eclk after MEM_RD start; the core's T2 is stretched
//    accordingly; no _wait on refresh cycles.
//  4 IO_WR to port 8'h10 with db_o=8'h5A -> io_out=8'h5A, io_wstb high 1 cycle.
//    IO_RD port 8'h10 with io_in=8'hC3 -> db_i=8'hC3. IO_RD port 8'h11 -> 8'hFF.
//  5 irq_vec=8'h20, pulse irq_req -> _int=0 until INTA; db_i=8'h20 during INTA; _int=1 after.
//  6 Assert ereset during WAITST of a MEM_WR -> _wait=1 and db_i=8'hFF immediately;
//    the target RAM byte is unchanged.

Source files
------------

// File: rtl/z80_bus_responder.sv
// Z80 external-bus target: RAM, one 8-bit I/O port, programmable _wait and a vectored interrupt.
// Cycles are recognised on the first eclk at which their strobe combination goes true.
module z80_bus_responder #(
  parameter int         ADDR_BITS = 12,
  parameter int         MEM_WAIT  = 0,
  parameter int         IO_WAIT   = 2,
  parameter logic [7:0] IO_PORT   = 8'h10,
  parameter             INIT_FILE = ""
) (
  input  logic        eclk,
  input  logic        ereset,
  input  logic [15:0] ab,
  input  logic [7:0]  db_o,
  input  logic        _m1,
  input  logic        _mreq,
  input  logic        _iorq,
  input  logic        _rd,
  input  logic        _wr,
  input  logic        _rfsh,
  output logic [7:0]  db_i,
  output logic        _wait,
  output logic        _int,
  input  logic        irq_req,
  input  logic [7:0]  irq_vec,
  input  logic [7:0]  io_in,
  output logic [7:0]  io_out,
  output logic        io_wstb
);

  typedef enum logic [1:0] {S_IDLE, S_WAITST, S_ACTIVE} state_t;
  typedef enum logic [2:0] {K_NONE, K_MEM_RD, K_MEM_WR, K_IO_RD, K_IO_WR, K_INTA} kind_t;

  localparam logic [3:0] LP_MEM_WAIT = 4'(MEM_WAIT);
  localparam logic [3:0] LP_IO_WAIT  = 4'(IO_WAIT);

  state_t               r_state, w_state_next;
  logic [3:0]           r_cnt, w_cnt_next;
  kind_t                r_kind, w_kind;
  logic [3:0]           w_wait_load;
  logic                 w_start;
  logic                 r_m1_p, r_mreq_p, r_iorq_p, r_rd_p, r_wr_p, r_rfsh_p;
  logic [ADDR_BITS-1:0] r_addr;
  logic                 r_port_hit;
  logic [7:0]           r_mem [0:(2**ADDR_BITS)-1];
  logic [7:0]           r_mem_q;
  logic                 r_src_mem;
  logic [7:0]           r_db;
  logic                 r_pend;
  logic [7:0]           r_io_out;
  logic                 r_io_wstb;

  generate
    if (ADDR_BITS < 16) begin : g_unused
      logic w_unused_ab;
      assign w_unused_ab = ^ab[15:ADDR_BITS];
    end
  endgenerate

  // A write strobe with _rd also low is treated as a read, so writes require _rd high.
  logic w_mem_rd_now, w_mem_wr_now, w_io_rd_now, w_io_wr_now, w_inta_now;
  logic w_mem_rd_prv, w_mem_wr_prv, w_io_rd_prv, w_io_wr_prv, w_inta_prv;
  assign w_mem_rd_now = ~_mreq & ~_rd & _rfsh;
  assign w_mem_wr_now = ~_mreq & ~_wr & _rd;
  assign w_io_rd_now  = ~_iorq & ~_rd & _m1;
  assign w_io_wr_now  = ~_iorq & ~_wr & _rd & _m1;
  assign w_inta_now   = ~_iorq & ~_m1;
  assign w_mem_rd_prv = ~r_mreq_p & ~r_rd_p & r_rfsh_p;
  assign w_mem_wr_prv = ~r_mreq_p & ~r_wr_p & r_rd_p;
  assign w_io_rd_prv  = ~r_iorq_p & ~r_rd_p & r_m1_p;
  assign w_io_wr_prv  = ~r_iorq_p & ~r_wr_p & r_rd_p & r_m1_p;
  assign w_inta_prv   = ~r_iorq_p & ~r_m1_p;

  logic w_idle, w_bus_idle, w_wr_commit, w_inta_start;
  assign w_idle       = (r_state == S_IDLE);
  assign w_bus_idle   = _mreq & _iorq;
  assign w_wr_commit  = (r_state == S_ACTIVE) & _wr & ~r_wr_p;
  assign w_inta_start = w_start & (w_kind == K_INTA);

  always_comb begin
    w_start     = 1'b1;
    w_kind      = K_NONE;
    w_wait_load = LP_MEM_WAIT;
    if (!w_idle)                          w_start = 1'b0;
    else if (w_mem_rd_now & ~w_mem_rd_prv) w_kind = K_MEM_RD;
    else if (w_mem_wr_now & ~w_mem_wr_prv) w_kind = K_MEM_WR;
    else if (w_inta_now & ~w_inta_prv) begin
      w_kind      = K_INTA;
      w_wait_load = LP_IO_WAIT;
    end else if (w_io_rd_now & ~w_io_rd_prv) begin
      w_kind      = K_IO_RD;
      w_wait_load = LP_IO_WAIT;
    end else if (w_io_wr_now & ~w_io_wr_prv) begin
      w_kind      = K_IO_WR;
      w_wait_load = LP_IO_WAIT;
    end else                              w_start = 1'b0;
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: if (w_start) begin
        w_cnt_next   = w_wait_load;
        w_state_next = (w_wait_load != 4'd0) ? S_WAITST : S_ACTIVE;
      end
      S_WAITST: begin
        if (w_bus_idle)         w_state_next = S_IDLE;
        else if (r_cnt <= 4'd1) w_state_next = S_ACTIVE;
        else                    w_cnt_next   = r_cnt - 4'd1;
      end
      S_ACTIVE: if (w_bus_idle) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_kind     <= K_NONE;
      r_m1_p     <= 1'b1;
      r_mreq_p   <= 1'b1;
      r_iorq_p   <= 1'b1;
      r_rd_p     <= 1'b1;
      r_wr_p     <= 1'b1;
      r_rfsh_p   <= 1'b1;
      r_addr     <= '0;
      r_port_hit <= 1'b0;
      r_src_mem  <= 1'b0;
      r_db       <= 8'hFF;
      r_pend     <= 1'b0;
      r_io_out   <= 8'h00;
      r_io_wstb  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_m1_p    <= _m1;
      r_mreq_p  <= _mreq;
      r_iorq_p  <= _iorq;
      r_rd_p    <= _rd;
      r_wr_p    <= _wr;
      r_rfsh_p  <= _rfsh;
      r_io_wstb <= 1'b0;
      if (w_start) begin
        r_kind     <= w_kind;
        r_addr     <= ab[ADDR_BITS-1:0];
        r_port_hit <= (ab[7:0] == IO_PORT);
        r_src_mem  <= (w_kind == K_MEM_RD);
        if (w_kind == K_IO_RD)     r_db <= (ab[7:0] == IO_PORT) ? io_in : 8'hFF;
        else if (w_kind == K_INTA) r_db <= irq_vec;
      end else if (!w_idle && w_bus_idle) begin
        r_src_mem <= 1'b0;
        r_db      <= 8'hFF;
      end
      // A new request on the INTA start edge wins over the acknowledge.
      if (irq_req)           r_pend <= 1'b1;
      else if (w_inta_start) r_pend <= 1'b0;
      if (w_wr_commit && r_kind == K_IO_WR && r_port_hit) begin
        r_io_out  <= db_o;
        r_io_wstb <= 1'b1;
      end
    end
  end

  // RAM kept reset-free with an enabled registered read so it maps onto block RAM.
  always_ff @(posedge eclk) begin
    if (w_wr_commit && r_kind == K_MEM_WR) r_mem[r_addr] <= db_o;
    if (w_start && w_kind == K_MEM_RD)     r_mem_q <= r_mem[ab[ADDR_BITS-1:0]];
  end

  assign db_i    = r_src_mem ? r_mem_q : r_db;
  assign _wait   = (r_state != S_WAITST);
  assign _int    = ~r_pend;
  assign io_out  = r_io_out;
  assign io_wstb = r_io_wstb;

endmodule
